pci_rr_arbiter: RTL and testbench



---
 rtl/pci_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_pci_rr_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pci_rr_arbiter.sv
// pci_rr_arbiter: round-robin central PCI arbiter with registered active-low one-hot grants.
// Define PCI_ARB_PARK_EN to park the bus on PARK_IDX while no agent requests.
module pci_rr_arbiter #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int TMO_CYC  = 16,
   parameter int PARK_IDX = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_n,
   input  logic             frame_n,
   input  logic             irdy_n,
   output logic [N_REQ-1:0] gnt_n,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             tmo_pulse
);
   localparam int CNT_W = $clog2(TMO_CYC + 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TMO_CYC - 1);
   localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
`ifdef PCI_ARB_PARK_EN
   localparam logic [IDX_W-1:0] PARK     = IDX_W'(PARK_IDX);
`endif
   typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;
   state_t state, state_d;
   logic [IDX_W-1:0] last_owner, last_d, idx_d, win_idx;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [N_REQ-1:0] own_mask;
   logic on_d, tmo_d, do_grant, any_req, own_req, other_req, bus_idle;
   assign own_mask  = ONE << gnt_idx;
   assign any_req   = ~&req_n;
   assign own_req   = |(~req_n & own_mask);
   assign other_req = |(~req_n & ~own_mask);
   assign bus_idle  = frame_n & irdy_n;
   // Walk from the farthest offset down so the nearest requester after last_owner wins.
   always_comb begin
      int j;
      win_idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         j = int'(last_owner) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!req_n[j]) win_idx = IDX_W'(j);
      end
   end
   always_comb begin
      state_d  = state;
      last_d   = last_owner;
      idx_d    = gnt_idx;
      on_d     = gnt_valid;
      cnt_d    = cnt;
      tmo_d    = 1'b0;
      do_grant = 1'b0;
      case (state)
         IDLE: begin
`ifdef PCI_ARB_PARK_EN
            if (gnt_valid && !frame_n) begin
               state_d = BUSY;
               last_d  = gnt_idx;
            end else if (any_req && gnt_valid && win_idx != PARK) begin
               state_d = TURN;
               on_d    = 1'b0;
            end else if (any_req) do_grant = 1'b1;
            else begin
               on_d  = 1'b1;
               idx_d = PARK;
            end
`else
            on_d     = 1'b0;
            do_grant = any_req;
`endif
         end
         GRANT: begin
            if (!frame_n) state_d = BUSY;
            else if (!own_req) begin
               state_d = TURN;
               on_d    = 1'b0;
            end else if (cnt == CNT_MAX) begin
               state_d = TURN;
               on_d    = 1'b0;
               tmo_d   = 1'b1;
            end else cnt_d = cnt + 1'b1;
         end
         BUSY: begin
            // Grant is withdrawn early on contention; handover waits for an idle bus.
            if (bus_idle && (!gnt_valid || !own_req)) begin
               state_d = TURN;
               on_d    = 1'b0;
            end else on_d = gnt_valid && own_req && !other_req;
         end
         default: begin
            on_d = 1'b0;
            if (any_req) do_grant = 1'b1;
            else state_d = IDLE;
         end
      endcase
      if (do_grant) begin
         state_d = GRANT;
         on_d    = 1'b1;
         idx_d   = win_idx;
         last_d  = win_idx;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= LAST_RST;
         gnt_idx    <= '0;
         gnt_valid  <= 1'b0;
         gnt_n      <= '1;
         cnt        <= '0;
         tmo_pulse  <= 1'b0;
      end else begin
         state      <= state_d;
         last_owner <= last_d;
         gnt_idx    <= idx_d;
         gnt_valid  <= on_d;
         gnt_n      <= on_d ? ~(ONE << idx_d) : '1;
         cnt        <= cnt_d;
         tmo_pulse  <= tmo_d;
      end
   end
endmodule

// File: tb/tb_pci_rr_arbiter.sv
// tb_pci_rr_arbiter: directed-vector bench for pci_rr_arbiter with the default 8-agent setup.
module tb_pci_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_n;
   logic       frame_n;
   logic       irdy_n;
   logic [7:0] gnt_n;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       tmo_pulse;
   int vectors = 0;
   int miscompares = 0;
   pci_rr_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
      .gnt_n(gnt_n), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .tmo_pulse(tmo_pulse)
   );
   always #5 clk = ~clk;
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0; req_n = 8'hFF; frame_n = 1'b1; irdy_n = 1'b1;
      tick(1);
      chk("rst_gnt_n", gnt_n, 8'hFF);
      chk("rst_valid", gnt_valid, 0);
      chk("rst_idx", gnt_idx, 0);
      chk("rst_tmo", tmo_pulse, 0);
      rst_n = 1'b1;
      tick(1);
`ifdef PCI_ARB_PARK_EN
      chk("park_idle", gnt_n, 8'hFE);
      chk("park_valid", gnt_valid, 1);
      req_n = 8'hFE; tick(1);
      chk("park_own_req", gnt_n, 8'hFE);
      req_n = 8'hFF; tick(1);
      chk("park_rel_turn", gnt_n, 8'hFF);
      tick(1);
      chk("park_rel_idle", gnt_n, 8'hFF);
      tick(1);
      chk("park_again", gnt_n, 8'hFE);
      req_n = 8'hEF; tick(1);
      chk("park_other_turn", gnt_n, 8'hFF);
      tick(1);
      chk("park_other_gnt", gnt_n, 8'hEF);
      chk("park_other_idx", gnt_idx, 4);
`else
      chk("idle_gnt_n", gnt_n, 8'hFF);
      req_n = 8'hF7; tick(1);
      chk("first_gnt_n", gnt_n, 8'hF7);
      chk("first_idx", gnt_idx, 3);
      chk("first_valid", gnt_valid, 1);
      req_n = 8'hFF; tick(1);
      chk("release_turn", gnt_n, 8'hFF);
      tick(1);
      chk("release_idx_hold", gnt_idx, 3);
      // Reset pulse between edges so agent 0 heads the rotation.
      #2 rst_n = 1'b0; #1 rst_n = 1'b1;
      req_n = 8'h00; tick(1);
      for (int k = 0; k < 9; k++) begin
         logic [7:0] e;
         e = ~(8'h01 << (k % 8));
         chk("rr_gnt_n", gnt_n, e);
         chk("rr_idx", gnt_idx, k % 8);
         frame_n = 1'b0; irdy_n = 1'b0; tick(1);
         chk("rr_busy_hold", gnt_n, e);
         frame_n = 1'b1; irdy_n = 1'b1; req_n = ~e; tick(1);
         chk("rr_turn", gnt_n, 8'hFF);
         req_n = (k < 8) ? 8'h00 : 8'hFF;
         tick(1);
      end
      chk("rr_idle", gnt_n, 8'hFF);
      req_n = 8'hBB; tick(1);
      chk("tmo_gnt", gnt_n, 8'hFB);
      tick(15);
      chk("tmo_still", gnt_n, 8'hFB);
      chk("tmo_not_yet", tmo_pulse, 0);
      tick(1);
      chk("tmo_drop", gnt_n, 8'hFF);
      chk("tmo_pulse", tmo_pulse, 1);
      tick(1);
      chk("tmo_pulse_end", tmo_pulse, 0);
      chk("tmo_next_gnt", gnt_n, 8'hBF);
      chk("tmo_next_idx", gnt_idx, 6);
      req_n = 8'hFF; tick(2);
      chk("tmo_idle", gnt_n, 8'hFF);
      req_n = 8'hFD; tick(1);
      chk("pre_gnt", gnt_n, 8'hFD);
      frame_n = 1'b0; irdy_n = 1'b0; tick(1);
      chk("pre_busy", gnt_n, 8'hFD);
      req_n = 8'hDD; tick(1);
      chk("pre_revoke", gnt_n, 8'hFF);
      chk("pre_valid", gnt_valid, 0);
      chk("pre_idx_hold", gnt_idx, 1);
      tick(1);
      chk("pre_wait_frame", gnt_n, 8'hFF);
      frame_n = 1'b1; tick(1);
      chk("pre_wait_irdy", gnt_n, 8'hFF);
      irdy_n = 1'b1; tick(1);
      chk("pre_turn", gnt_n, 8'hFF);
      tick(1);
      chk("pre_new_gnt", gnt_n, 8'hDF);
      chk("pre_new_idx", gnt_idx, 5);
      frame_n = 1'b0; tick(1);
      chk("arst_busy", gnt_n, 8'hDF);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt_n", gnt_n, 8'hFF);
      chk("arst_valid", gnt_valid, 0);
      chk("arst_idx", gnt_idx, 0);
      rst_n = 1'b1; frame_n = 1'b1; req_n = 8'h00; tick(1);
      chk("arst_first", gnt_n, 8'hFE);
      chk("arst_first_idx", gnt_idx, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
